// File: rtl/matrix_stream_tx_if.sv
// Element stream carried from matrix_stream_tx to a narrow consumer.
// The beat fields are valid while out_valid is high; a beat transfers when out_ready is also high.
interface matrix_stream_tx_if #(
  parameter int bitlength = 8,
  parameter int H = 7,
  parameter int W = 7
);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic                 out_valid;
  logic                 out_ready;
  logic [bitlength-1:0] out_data;
  logic [RW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/matrix_stream_tx.sv
// Captures a packed H x W matrix and streams it row-major, one element per handshake.
// done pulses for one cycle after the final beat is accepted.
module matrix_stream_tx #(
  parameter int bitlength = 8,
  parameter int H = 7,
  parameter int W = 7,
  localparam int RW = (H > 1) ? $clog2(H) : 1,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [H*W*bitlength-1:0]   mat_in,
  output logic                       busy,
  output logic                       done,
  matrix_stream_tx_if.master         stream
);
  localparam int N  = H * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_END = RW'(H - 1);
  localparam logic [CW-1:0] COL_END = CW'(W - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                   state, state_next;
  logic [N*bitlength-1:0]   mat_q;
  logic [IW-1:0]            idx_q, idx_next;
  logic [RW-1:0]            row_q, row_next;
  logic [CW-1:0]            col_q, col_next;
  logic [bitlength-1:0]     data_q;
  logic                     last_q;
  logic                     done_q;
  logic                     start, fire, fire_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // load is only honoured from IDLE, so a load coincident with the last beat is dropped
  always_comb begin
    state_next = state;
    start      = 1'b0;
    fire       = 1'b0;
    fire_last  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start      = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (stream.out_ready) begin
          fire = 1'b1;
          if (last_q) begin
            fire_last  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Flat index tracks row*W+col so the next element is selected without a multiplier on row
  always_comb begin
    idx_next = idx_q + 1'b1;
    row_next = row_q;
    col_next = col_q + 1'b1;
    if (col_q == COL_END) begin
      col_next = '0;
      row_next = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q  <= '0;
      idx_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fire_last;
      if (start) begin
        mat_q  <= mat_in;
        idx_q  <= '0;
        row_q  <= '0;
        col_q  <= '0;
        data_q <= mat_in[bitlength-1:0];
        last_q <= (N == 1);
      end else if (fire_last) begin
        idx_q  <= '0;
        row_q  <= '0;
        col_q  <= '0;
        data_q <= '0;
        last_q <= 1'b0;
      end else if (fire) begin
        idx_q  <= idx_next;
        row_q  <= row_next;
        col_q  <= col_next;
        data_q <= mat_q[idx_next*bitlength +: bitlength];
        last_q <= (row_next == ROW_END) && (col_next == COL_END);
      end
    end
  end

  assign busy             = (state == STREAM);
  assign done             = done_q;
  assign stream.out_valid = (state == STREAM);
  assign stream.out_data  = data_q;
  assign stream.out_row   = row_q;
  assign stream.out_col   = col_q;
  assign stream.out_last  = last_q;
endmodule
